// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle for sync_fifo_param: producer/consumer side is the
// master modport, the FIFO itself is the slave modport.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;
  logic [CW-1:0]    counter;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, empty, full, almost_empty, almost_full,
           overflow, underflow, counter
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, empty, full, almost_empty, almost_full,
           overflow, underflow, counter
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output (zero read latency).
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = 60,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             empty_s, full_s;
  logic             wr_acc, rd_acc;

  // A full FIFO still takes a write when the same cycle pops a word.
  always_comb begin
    empty_s     = (count_q == '0);
    full_s      = (count_q == CW'(DEPTH));
    rd_acc      = bus.rd_en & ~empty_s;
    wr_acc      = bus.wr_en & (~full_s | bus.rd_en);
    wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d  = bus.wr_en & ~wr_acc;
    underflow_d = bus.rd_en & ~rd_acc;
    count_d     = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out_q <= '0;
    else     data_out_q <= data_out_d;
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.counter      = count_q;
  assign bus.empty        = empty_s;
  assign bus.full         = full_s;
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AF    = 60;
  localparam int AE    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rst_gen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_cycle(input bit w, input logic [WIDTH-1:0] d, input bit r);
    int n;
    bit racc, wacc;
    bus.wr_en   = w;
    bus.data_in = d;
    bus.rd_en   = r;
    n    = model_q.size();
    racc = r && (n > 0);
    wacc = w && ((n < DEPTH) || r);
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(d);
    @(posedge clk);
    #1;
    n = model_q.size();
    chk("counter",      int'(bus.counter),      n);
    chk("empty",        int'(bus.empty),        int'(n == 0));
    chk("full",         int'(bus.full),         int'(n == DEPTH));
    chk("almost_empty", int'(bus.almost_empty), int'(n <= AE));
    chk("almost_full",  int'(bus.almost_full),  int'(n >= AF));
    chk("overflow",     int'(bus.overflow),     int'(w && !wacc));
    chk("underflow",    int'(bus.underflow),    int'(r && !racc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic run_monitor();
    int seen = 0;
    bit pend = 1'b0;
    logic [WIDTH-1:0] last = '0;
    forever begin
      @(negedge clk);
      if (seen != rst_gen) begin
        seen = rst_gen;
        pend = 1'b0;
        last = '0;
      end
`ifdef SYNC_FIFO_FWFT_EN
      if (bus.rd_en && !bus.empty && !rst) begin
        if (exp_q.size() == 0) chk("spurious_read", 1, 0);
        else chk("data_out", int'(bus.data_out), int'(exp_q.pop_front()));
      end
`else
      if (pend) begin
        if (exp_q.size() == 0) chk("spurious_read", 1, 0);
        else last = exp_q.pop_front();
      end
      chk("data_out", int'(bus.data_out), int'(last));
      pend = bus.rd_en && !bus.empty && !rst;
`endif
    end
  endtask

  task automatic run_main();
    int wprob, rprob;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
    rst = 1'b1;
    #12;
    chk("rst_counter", int'(bus.counter), 0);
    chk("rst_empty",   int'(bus.empty),   1);
    rst = 1'b0;
    idle(3);

    for (int i = 1; i <= 12; i++) do_cycle(1'b1, 8'(i * 8'h11), 1'b0);
    for (int i = 0; i < 12; i++)  do_cycle(1'b0, '0, 1'b1);
    idle(2);

    for (int i = 0; i < 64; i++) do_cycle(1'b1, 8'(i), 1'b0);
    do_cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 64; i++) do_cycle(1'b0, '0, 1'b1);
    idle(2);

    for (int i = 0; i < 64; i++) do_cycle(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 8'(8'hA0 + i), 1'b1);
    for (int i = 0; i < 64; i++) do_cycle(1'b0, '0, 1'b1);
    idle(2);

    do_cycle(1'b0, '0, 1'b1);
    do_cycle(1'b1, 8'h5A, 1'b1);
    do_cycle(1'b0, '0, 1'b1);
    idle(2);

    for (int i = 0; i < 20; i++) do_cycle(1'b1, 8'(8'h30 + i), 1'b0);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    #1;
    rst = 1'b1;
    rst_gen++;
    model_q.delete();
    exp_q.delete();
    #1;
    chk("async_rst_counter", int'(bus.counter), 0);
    chk("async_rst_empty",   int'(bus.empty),   1);
    rst = 1'b0;
    do_cycle(1'b1, 8'h77, 1'b0);
    do_cycle(1'b0, '0, 1'b1);
    idle(2);

    for (int p = 0; p < 15; p++) begin
      case (p % 3)
        0:       begin wprob = 85; rprob = 20; end
        1:       begin wprob = 15; rprob = 85; end
        default: begin wprob = 50; rprob = 50; end
      endcase
      for (int i = 0; i < 200; i++)
        do_cycle(($urandom_range(99) < wprob), 8'($urandom), ($urandom_range(99) < rprob));
    end

    for (int i = 0; i < 2 * DEPTH && model_q.size() > 0; i++) do_cycle(1'b0, '0, 1'b1);
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("model_drained", model_q.size(), 0);
  endtask

  initial begin
    fork
      run_main();
      run_monitor();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
